// File: rtl/noc_switch_pkg.sv
// Shared definitions for the xpipes switch datapath: default flit width,
// default output-buffer depth, and the pointer-width helper used to size
// FIFO pointers.
package noc_switch_pkg;

  localparam int SWITCH_FLIT_WIDTH = 80;
  localparam int OUTBUF_DEPTH      = 6;

  // Bits needed to index `depth` slots; never less than one bit.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/switch_outbuf_ptr.sv
// Wrap-at-DEPTH FIFO pointer with increment enable. The wrap is an explicit
// compare against DEPTH-1, so non-power-of-two depths step 0..DEPTH-1 only.
module switch_outbuf_ptr
  import noc_switch_pkg::*;
#(
  parameter int DEPTH = OUTBUF_DEPTH,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // Advance on inc, wrapping from DEPTH-1 back to zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/switch_output_buffer.sv
// Per-output-port flit FIFO for the xpipes switch. Captures the crossbar flit
// when the allocator asserts valid, back-pressures the allocator through
// busy_out (decoded from registered fill state only), and presents flits to
// the link with a stall/go handshake. Flits leave strictly in arrival order.
//
// Optional feature: define SWITCH_OUTBUF_BYPASS_EN to let a flit arriving at
// an empty buffer appear on flit_out in the same cycle (0-cycle latency).
// Without it, flit_out/valid_out come only from registers and memory.
module switch_output_buffer
  import noc_switch_pkg::*;
#(
  parameter int FLIT_WIDTH = SWITCH_FLIT_WIDTH,
  parameter int DEPTH      = OUTBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  input  logic                  valid_in,
  output logic                  busy_out,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  valid_out,
  input  logic                  stall_in,
  output logic                  overflow_err
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign busy_out = full;

`ifdef SWITCH_OUTBUF_BYPASS_EN
  // A flit hitting an empty buffer is shown directly on the link. If the
  // link takes it, it is consumed without ever being stored; if stalled, it
  // is written normally and read from memory on later cycles.
  logic bypass_take;
  assign bypass_take = rst & empty & valid_in & ~stall_in;
  assign valid_out   = ~empty | (rst & valid_in);
  assign flit_out    = empty ? flit_in : mem[rd_ptr];
  assign wr_en       = valid_in & ~full & ~bypass_take;
`else
  assign valid_out   = ~empty;
  assign flit_out    = mem[rd_ptr];
  assign wr_en       = valid_in & ~full;
`endif

  // Only stored flits advance the read pointer; bypassed flits never touch it.
  assign rd_en = ~empty & ~stall_in;

  switch_outbuf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_en),
    .ptr (wr_ptr)
  );

  switch_outbuf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_en),
    .ptr (rd_ptr)
  );

  // Flit storage: write the accepted flit at wr_ptr.
  // NOTE: the array is deliberately left out of reset; count/valid_out mark
  // which slots are live, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= flit_in;
    end
  end

  // Occupancy: +1 on write only, -1 on read only, hold on both or neither.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky protocol-violation flag: allocator pushed while we reported busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_err <= 1'b0;
    end else if (valid_in && full) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_output_buffer.sv
// Directed self-checking bench for switch_output_buffer (DEPTH=6, 80-bit
// flits). Inputs change 1 ns after a rising edge; outputs are sampled 1 ns
// later, well away from the next edge.
module tb_switch_output_buffer;

  localparam int W = 80;
  localparam int D = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] flit_in;
  logic         valid_in;
  logic         busy_out;
  logic [W-1:0] flit_out;
  logic         valid_out;
  logic         stall_in;
  logic         overflow_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  switch_output_buffer #(.FLIT_WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_in      (flit_in),
    .valid_in     (valid_in),
    .busy_out     (busy_out),
    .flit_out     (flit_out),
    .valid_out    (valid_out),
    .stall_in     (stall_in),
    .overflow_err (overflow_err)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] q[$];
  int sent;
  int rcvd;

  initial begin
    // Reset then idle, with valid_in held high throughout reset.
    rst      = 1'b0;
    valid_in = 1'b1;
    stall_in = 1'b0;
    flit_in  = W'(32'h99);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check("rst_valid_out", W'(valid_out), W'(1'b0));
      check("rst_busy_out",  W'(busy_out),  W'(1'b0));
      check("rst_overflow",  W'(overflow_err), W'(1'b0));
    end
    tick();
    rst      = 1'b1;
    valid_in = 1'b0;
    #1;
    check("rst_count", W'(dut.count), W'(0));

`ifndef SWITCH_OUTBUF_BYPASS_EN
    // Single flit, registered path: visible exactly one cycle after write.
    tick();
    valid_in = 1'b1;
    flit_in  = W'(8'hA5);
    #1;
    check("single_pre_valid", W'(valid_out), W'(1'b0));
    tick();
    valid_in = 1'b0;
    #1;
    check("single_valid", W'(valid_out), W'(1'b1));
    check("single_data",  flit_out,      W'(8'hA5));
    tick();
    #1;
    check("single_post_valid", W'(valid_out), W'(1'b0));
    check("single_post_count", W'(dut.count), W'(0));
`else
    // Bypass: empty buffer, link ready -> same-cycle output, nothing stored.
    tick();
    valid_in = 1'b1;
    flit_in  = W'(8'h3C);
    #1;
    check("bypass_valid", W'(valid_out), W'(1'b1));
    check("bypass_data",  flit_out,      W'(8'h3C));
    tick();
    valid_in = 1'b0;
    #1;
    check("bypass_count", W'(dut.count), W'(0));
    // Bypass with stall: flit is stored and valid_out is already high.
    valid_in = 1'b1;
    stall_in = 1'b1;
    flit_in  = W'(8'h5A);
    #1;
    check("bypass_stall_valid", W'(valid_out), W'(1'b1));
    tick();
    valid_in = 1'b0;
    stall_in = 1'b0;
    #1;
    check("bypass_stall_count", W'(dut.count), W'(1));
    check("bypass_stall_data",  flit_out,      W'(8'h5A));
    tick();
    #1;
    check("bypass_drain_count", W'(dut.count), W'(0));
`endif

    // Fill under backpressure: busy must stay low through all six writes.
    stall_in = 1'b1;
    for (int i = 1; i <= D; i++) begin
      tick();
      valid_in = 1'b1;
      flit_in  = W'(i);
      #1;
      check("fill_busy_low", W'(busy_out), W'(1'b0));
    end
    tick();
    valid_in = 1'b0;
    #1;
    check("full_busy",  W'(busy_out),  W'(1'b1));
    check("full_count", W'(dut.count), W'(D));
    check("full_valid", W'(valid_out), W'(1'b1));
    check("full_head",  flit_out,      W'(1));

    // Full plus read: the push is dropped and flagged, the pop proceeds.
    tick();
    valid_in = 1'b1;
    flit_in  = W'(8'h77);
    stall_in = 1'b0;
    #1;
    check("fr_busy_same_cycle", W'(busy_out), W'(1'b1));
    check("fr_head",            flit_out,     W'(1));
    tick();
    valid_in = 1'b0;
    #1;
    check("fr_count",    W'(dut.count),    W'(D - 1));
    check("fr_overflow", W'(overflow_err), W'(1'b1));
    check("fr_busy_low", W'(busy_out),     W'(1'b0));

    // Drain the rest: 2..6 on consecutive cycles, 0x77 must never appear.
    for (int i = 2; i <= D; i++) begin
      check("drain_valid", W'(valid_out), W'(1'b1));
      check("drain_data",  flit_out,      W'(i));
      tick();
      #1;
    end
    check("drain_empty",     W'(valid_out),    W'(1'b0));
    check("drain_count",     W'(dut.count),    W'(0));
    check("overflow_sticky", W'(overflow_err), W'(1'b1));

    // Reset mid-operation discards stored flits and clears the error.
    tick();
    valid_in = 1'b1;
    stall_in = 1'b1;
    flit_in  = W'(8'h0A);
    tick();
    tick();
    valid_in = 1'b0;
    #1;
    check("mid_count", W'(dut.count), W'(2));
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_count",    W'(dut.count),    W'(0));
    check("mid_rst_valid",    W'(valid_out),    W'(1'b0));
    check("mid_rst_overflow", W'(overflow_err), W'(1'b0));
    check("mid_rst_busy",     W'(busy_out),     W'(1'b0));

    // Wrap-around stream: 20 flits with random stall, obeying busy_out.
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
      tick();
      stall_in = 1'($urandom_range(0, 1));
      if (sent < 20 && !busy_out) begin
        valid_in = 1'b1;
        flit_in  = W'(32'hC0DE_0000 + sent);
        q.push_back(flit_in);
        sent++;
      end else begin
        valid_in = 1'b0;
      end
      #1;
      if (valid_out && !stall_in) begin
        if (q.size() == 0) begin
          check("stream_spurious", W'(valid_out), W'(1'b0));
        end else begin
          check("stream_data", flit_out, q.pop_front());
        end
        rcvd++;
      end
    end
    valid_in = 1'b0;
    check("stream_count",    W'(rcvd),         W'(20));
    check("stream_leftover", W'(q.size()),     W'(0));
    check("stream_overflow", W'(overflow_err), W'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
